// File: rtl/sd_req_arbiter_if.sv
// Signal bundle between the SD slot arbiter, its core-side requesters and hps_io.
// The master modport is the arbiter's view; slave is the surrounding logic.
interface sd_req_arbiter_if #(
  parameter int N = 2
);
  logic [N-1:0]    cl_rd;
  logic [N-1:0]    cl_wr;
  logic [32*N-1:0] cl_lba;
  logic [N-1:0]    cl_ack;
  logic [N-1:0]    cl_done;
  logic [N-1:0]    cl_err;
  logic [N-1:0]    cl_buff_wr;
  logic [8*N-1:0]  cl_buff_din;
  logic [31:0]     sd_lba;
  logic            sd_rd;
  logic            sd_wr;
  logic            sd_ack;
  logic            sd_buff_wr;
  logic [7:0]      sd_buff_din;
  logic            busy;
  logic [2:0]      grant;

  modport master (
    input  cl_rd, cl_wr, cl_lba, cl_buff_din, sd_ack, sd_buff_wr,
    output cl_ack, cl_done, cl_err, cl_buff_wr, sd_lba, sd_rd, sd_wr, sd_buff_din, busy, grant
  );

  modport slave (
    output cl_rd, cl_wr, cl_lba, cl_buff_din, sd_ack, sd_buff_wr,
    input  cl_ack, cl_done, cl_err, cl_buff_wr, sd_lba, sd_rd, sd_wr, sd_buff_din, busy, grant
  );
endinterface

// File: rtl/sd_req_arbiter.sv
// Round-robin arbiter sharing one hps_io SD block slot among N requesters,
// with one block transaction in flight and sd_buff traffic steered to the grantee.
module sd_req_arbiter #(
  parameter int          N       = 2,
  parameter logic [23:0] TIMEOUT = 24'hFFFFFF
) (
  input  logic            clk_sys,
  input  logic            reset,
  sd_req_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, XFER, DONE} state_t;

  localparam logic [23:0] TIMER_LAST = TIMEOUT - 24'd1;
  localparam logic [2:0]  LAST_INIT  = 3'(N - 1);

  state_t       state_q, state_d;
  logic [2:0]   grant_q, grant_d;
  logic [2:0]   last_q, last_d;
  logic [31:0]  lba_q, lba_d;
  logic         rd_q, rd_d;
  logic         wr_q, wr_d;
  logic [23:0]  timer_q, timer_d;
  logic [N-1:0] done_q, done_d;
  logic [N-1:0] err_q, err_d;

  logic         hi_valid, lo_valid, pick_valid, pick_rd;
  logic [2:0]   hi_idx, lo_idx, pick;
  logic [31:0]  pick_lba;
  logic [N-1:0] grant_oh;
  logic [7:0]   sel_din;

  // Priority rotates: the lowest requester above the last grantee wins, else wrap to
  // the lowest requester overall. The descending scan leaves the lowest index behind.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    hi_valid = 1'b0;
    lo_valid = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    pick_lba = '0;
    pick_rd  = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (bus.cl_rd[i] || bus.cl_wr[i]) begin
        lo_valid = 1'b1;
        lo_idx   = 3'(i);
        if (3'(i) > last_q) begin
          hi_valid = 1'b1;
          hi_idx   = 3'(i);
        end
      end
    end
    pick_valid = lo_valid;
    pick       = hi_valid ? hi_idx : lo_idx;
    for (int i = 0; i < N; i++) begin
      if (pick == 3'(i)) begin
        pick_lba = bus.cl_lba[32*i +: 32];
        pick_rd  = bus.cl_rd[i];
      end
    end
  end

  always_comb begin
    grant_oh = '0;
    sel_din  = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_q == 3'(i)) begin
        grant_oh[i] = 1'b1;
        sel_din     = bus.cl_buff_din[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    lba_d   = lba_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    timer_d = timer_q;
    done_d  = '0;
    err_d   = '0;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d = pick;
          lba_d   = pick_lba;
          rd_d    = pick_rd;
          wr_d    = !pick_rd;
          timer_d = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        timer_d = timer_q + 24'd1;
        // An ack that is already high on entry counts; it takes precedence over a timeout.
        if (bus.sd_ack) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = XFER;
        end else if (TIMEOUT != 24'd0 && timer_q == TIMER_LAST) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          err_d   = grant_oh;
          last_d  = grant_q;
          state_d = IDLE;
        end
      end
      XFER: begin
        if (!bus.sd_ack) begin
          done_d  = grant_oh;
          state_d = DONE;
        end
      end
      DONE: begin
        last_d  = grant_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= LAST_INIT;
      lba_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      timer_q <= '0;
      done_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      lba_q   <= lba_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      timer_q <= timer_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.sd_lba      = lba_q;
  assign bus.sd_rd       = rd_q;
  assign bus.sd_wr       = wr_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.grant       = grant_q;
  assign bus.cl_done     = done_q;
  assign bus.cl_err      = err_q;
  assign bus.sd_buff_din = (state_q != IDLE) ? sel_din : 8'h00;
  // Ack and buffer strobes pass straight through to the grantee, same cycle.
  assign bus.cl_ack      = ((state_q == ISSUE || state_q == XFER) && bus.sd_ack) ? grant_oh : '0;
  assign bus.cl_buff_wr  = (state_q == XFER && bus.sd_buff_wr) ? grant_oh : '0;

endmodule

// File: tb/tb_sd_req_arbiter.sv
// Self-checking bench for sd_req_arbiter: directed scenarios plus randomized traffic
// compared against a distance-based round-robin reference model.
module tb_sd_req_arbiter;

  localparam int          N   = 3;
  localparam logic [23:0] TMO = 24'd16;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic [31:0] lba_arr [N];
  logic [7:0]  din_arr [N];

  int total  = 0;
  int bad    = 0;
  int last_m = N - 1;

  sd_req_arbiter_if #(.N(N)) bus ();

  sd_req_arbiter #(.N(N), .TIMEOUT(TMO)) dut (
    .clk_sys (clk),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      bus.cl_lba[32*i +: 32]     = lba_arr[i];
      bus.cl_buff_din[8*i +: 8] = din_arr[i];
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "bench watchdog expired");
  end

  typedef struct packed {
    int           wait_n;
    logic         timed_out;
    logic [2:0]   grant;
    logic         rd;
    logic         wr;
    logic [31:0]  lba;
    int           unstable;
    logic [N-1:0] ack_vec;
    logic [N-1:0] ack_after_drop;
    logic [N-1:0] done_vec;
    logic [N-1:0] err_or;
    logic [1:0]   cmd_after_ack;
    int           good_bytes;
    int           done_cnt;
    logic         busy_after;
  } obs_t;

  // Reference: the winner is the requester at the smallest forward distance past last.
  function automatic int model_pick(input logic [N-1:0] req, input int last);
    int best   = -1;
    int best_d = N;
    int d;
    for (int i = 0; i < N; i++) begin
      if (req[i]) begin
        d = (i - last - 1 + 2 * N) % N;
        if (d < best_d) begin
          best_d = d;
          best   = i;
        end
      end
    end
    return best;
  endfunction

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] r;
    r    = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  // Plays hps_io for one block transaction and records what the DUT showed.
  task automatic serve(input int exp_g, input logic [7:0] exp_din, input int ack_delay,
                       input int nbytes, input bit drop_req, input bit fiddle, output obs_t o);
    logic [N-1:0] exp_oh;
    exp_oh = onehot(exp_g);
    o = '0;
    while (!(bus.sd_rd || bus.sd_wr) && o.wait_n < 40) begin
      @(negedge clk);
      o.wait_n++;
    end
    if (!(bus.sd_rd || bus.sd_wr)) begin
      o.timed_out = 1'b1;
      return;
    end
    o.grant = bus.grant;
    o.rd    = bus.sd_rd;
    o.wr    = bus.sd_wr;
    o.lba   = bus.sd_lba;
    for (int c = 0; c < ack_delay; c++) begin
      if (fiddle) begin
        bus.cl_rd[exp_g] = 1'b0;
        bus.cl_wr[exp_g] = 1'b0;
        lba_arr[exp_g]   = $urandom;
      end
      @(negedge clk);
      if ({bus.sd_rd, bus.sd_wr, bus.sd_lba} !== {o.rd, o.wr, o.lba}) o.unstable++;
      o.err_or |= bus.cl_err;
    end
    bus.sd_ack = 1'b1;
    if (drop_req) begin
      bus.cl_rd[exp_g] = 1'b0;
      bus.cl_wr[exp_g] = 1'b0;
    end
    #1 o.ack_vec = bus.cl_ack;
    @(negedge clk);
    o.cmd_after_ack = {bus.sd_rd, bus.sd_wr};
    for (int b = 0; b < nbytes; b++) begin
      bus.sd_buff_wr = 1'b1;
      #1;
      if (bus.cl_buff_wr === exp_oh && bus.sd_buff_din === exp_din && bus.cl_ack === exp_oh)
        o.good_bytes++;
      @(negedge clk);
      bus.sd_buff_wr = 1'b0;
      @(negedge clk);
    end
    bus.sd_ack = 1'b0;
    #1 o.ack_after_drop = bus.cl_ack;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      if (|bus.cl_done) begin
        o.done_cnt++;
        o.done_vec |= bus.cl_done;
      end
      if (c == 1) o.busy_after = bus.busy;
    end
  endtask

  task automatic test_reset();
    reset          = 1'b1;
    bus.sd_ack     = 1'b1;
    bus.sd_buff_wr = 1'b1;
    for (int i = 0; i < N; i++) din_arr[i] = 8'h11 * 8'(i + 1);
    repeat (2) @(negedge clk);
    total++;
    if ({bus.sd_rd, bus.sd_wr, bus.sd_lba, bus.grant, bus.busy} !== '0) begin
      bad++;
      $display("FAIL reset_cmd got rd=%b wr=%b lba=%h grant=%0d busy=%b want all 0",
               bus.sd_rd, bus.sd_wr, bus.sd_lba, bus.grant, bus.busy);
    end
    total++;
    if ({bus.cl_ack, bus.cl_done, bus.cl_err, bus.cl_buff_wr, bus.sd_buff_din} !== '0) begin
      bad++;
      $display("FAIL reset_client got ack=%b done=%b err=%b bwr=%b din=%h want all 0",
               bus.cl_ack, bus.cl_done, bus.cl_err, bus.cl_buff_wr, bus.sd_buff_din);
    end
    reset      = 1'b0;
    bus.sd_ack = 1'b0;
    @(negedge clk);
    total++;
    if ({bus.cl_buff_wr, bus.sd_buff_din, bus.busy} !== '0) begin
      bad++;
      $display("FAIL idle_stray_buff got bwr=%b din=%h busy=%b want 0",
               bus.cl_buff_wr, bus.sd_buff_din, bus.busy);
    end
    bus.sd_buff_wr = 1'b0;
    last_m = N - 1;
  endtask

  task automatic test_single_read();
    obs_t o;
    int   g;
    lba_arr[1] = 32'h0000_1234;
    bus.cl_rd  = 3'b010;
    g = model_pick(bus.cl_rd, last_m);
    serve(g, din_arr[g], 5, 512, 1'b1, 1'b0, o);
    total++;
    if (o.timed_out !== 1'b0 || o.wait_n !== 1) begin
      bad++;
      $display("FAIL t1_issue_latency got wait=%0d to=%b want 1", o.wait_n, o.timed_out);
    end
    total++;
    if ({o.grant, o.rd, o.wr, o.lba} !== {3'(g), 1'b1, 1'b0, 32'h1234}) begin
      bad++;
      $display("FAIL t1_cmd got g=%0d rd=%b wr=%b lba=%h want g=%0d rd=1 wr=0 lba=1234",
               o.grant, o.rd, o.wr, o.lba, g);
    end
    total++;
    if (o.ack_vec !== 3'b010 || o.cmd_after_ack !== 2'b00) begin
      bad++;
      $display("FAIL t1_ack got cl_ack=%b cmd=%b want 010 00", o.ack_vec, o.cmd_after_ack);
    end
    total++;
    if (o.good_bytes !== 512) begin
      bad++;
      $display("FAIL t1_buff_wr got=%0d want=512", o.good_bytes);
    end
    total++;
    if (o.ack_after_drop !== 3'b000 || o.done_vec !== 3'b010 || o.done_cnt !== 1) begin
      bad++;
      $display("FAIL t1_done got ack=%b done=%b cnt=%0d want 000 010 1",
               o.ack_after_drop, o.done_vec, o.done_cnt);
    end
    total++;
    if (o.busy_after !== 1'b0) begin
      bad++;
      $display("FAIL t1_busy_after got=%b want=0", o.busy_after);
    end
    last_m = g;
  endtask

  task automatic test_round_robin();
    obs_t o;
    int   g;
    reset     = 1'b1;
    bus.cl_rd = 3'b111;
    repeat (2) @(negedge clk);
    reset  = 1'b0;
    last_m = N - 1;
    for (int k = 0; k < 4; k++) begin
      g = model_pick(bus.cl_rd, last_m);
      serve(g, din_arr[g], 2, 2, 1'b0, 1'b0, o);
      total++;
      if (o.grant !== 3'(g) || o.wait_n !== 1 || o.done_vec !== onehot(g)) begin
        bad++;
        $display("FAIL rr_order k=%0d got g=%0d wait=%0d done=%b want g=%0d wait=1 done=%b",
                 k, o.grant, o.wait_n, o.done_vec, g, onehot(g));
      end
      last_m = g;
    end
    bus.cl_rd = '0;
  endtask

  task automatic test_write_data();
    obs_t o;
    int   g;
    for (int i = 0; i < N; i++) begin
      din_arr[i] = 8'($urandom);
      if (din_arr[i] == 8'hA5) din_arr[i] = 8'h3C;
      lba_arr[i] = $urandom;
    end
    din_arr[2] = 8'hA5;
    bus.cl_wr  = 3'b100;
    g = model_pick(bus.cl_wr, last_m);
    serve(g, 8'hA5, 1, 4, 1'b1, 1'b0, o);
    total++;
    if ({o.rd, o.wr, o.lba} !== {1'b0, 1'b1, lba_arr[2]}) begin
      bad++;
      $display("FAIL t3_write_cmd got rd=%b wr=%b lba=%h want rd=0 wr=1 lba=%h",
               o.rd, o.wr, o.lba, lba_arr[2]);
    end
    total++;
    if (o.good_bytes !== 4) begin
      bad++;
      $display("FAIL t3_write_din got=%0d want=4", o.good_bytes);
    end
    last_m = g;
  endtask

  task automatic test_rd_wins();
    obs_t o;
    int   g;
    bus.cl_rd = 3'b001;
    bus.cl_wr = 3'b001;
    g = model_pick(bus.cl_rd | bus.cl_wr, last_m);
    serve(g, din_arr[g], 0, 1, 1'b1, 1'b0, o);
    total++;
    if ({o.grant, o.rd, o.wr} !== {3'(g), 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL t4_rd_wins got g=%0d rd=%b wr=%b want g=%0d rd=1 wr=0",
               o.grant, o.rd, o.wr, g);
    end
    last_m = g;
  endtask

  task automatic test_timeout();
    int n = 0;
    int w = 0;
    int g;
    bus.cl_rd = 3'b001;
    g = model_pick(bus.cl_rd, last_m);
    while (!bus.sd_rd && w < 40) begin
      @(negedge clk);
      w++;
    end
    while (bus.sd_rd && n < 60) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n !== int'(TMO)) begin
      bad++;
      $display("FAIL t5_timeout_cycles got=%0d want=%0d", n, TMO);
    end
    total++;
    if ({bus.cl_err, bus.busy, bus.sd_rd, bus.cl_done} !== {onehot(g), 1'b0, 1'b0, 3'b000}) begin
      bad++;
      $display("FAIL t5_abort got err=%b busy=%b rd=%b done=%b want err=%b busy=0 rd=0 done=000",
               bus.cl_err, bus.busy, bus.sd_rd, bus.cl_done, onehot(g));
    end
    bus.cl_rd = '0;
    @(negedge clk);
    total++;
    if (bus.cl_err !== 3'b000) begin
      bad++;
      $display("FAIL t5_err_pulse got=%b want=000", bus.cl_err);
    end
    last_m = g;
  endtask

  task automatic test_random();
    obs_t         o;
    int           g, op, delay, nb;
    logic         exp_rd;
    logic [31:0]  exp_lba;
    logic [7:0]   exp_din;
    bit           fid;
    for (int t = 0; t < 24; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!(bus.cl_rd[i] || bus.cl_wr[i]) && $urandom_range(0, 1) == 1) begin
          op = $urandom_range(0, 2);
          bus.cl_rd[i] = (op != 1);
          bus.cl_wr[i] = (op != 0);
          lba_arr[i]   = $urandom;
          din_arr[i]   = 8'($urandom);
        end
      end
      if ((bus.cl_rd | bus.cl_wr) == '0) bus.cl_rd[$urandom_range(0, N - 1)] = 1'b1;
      g       = model_pick(bus.cl_rd | bus.cl_wr, last_m);
      exp_rd  = bus.cl_rd[g];
      exp_lba = lba_arr[g];
      exp_din = din_arr[g];
      fid     = ($urandom_range(0, 3) == 0);
      delay   = $urandom_range(0, 10);
      nb      = $urandom_range(1, 6);
      serve(g, exp_din, delay, nb, 1'b1, fid, o);
      total++;
      if (o.timed_out !== 1'b0 || o.wait_n !== 1 || o.grant !== 3'(g)) begin
        bad++;
        $display("FAIL rand_grant t=%0d got g=%0d wait=%0d to=%b want g=%0d wait=1",
                 t, o.grant, o.wait_n, o.timed_out, g);
      end
      total++;
      if ({o.rd, o.wr, o.lba} !== {exp_rd, !exp_rd, exp_lba} || o.unstable !== 0) begin
        bad++;
        $display("FAIL rand_cmd t=%0d got rd=%b wr=%b lba=%h unstable=%0d want rd=%b wr=%b lba=%h",
                 t, o.rd, o.wr, o.lba, o.unstable, exp_rd, !exp_rd, exp_lba);
      end
      total++;
      if (o.ack_vec !== onehot(g) || o.cmd_after_ack !== 2'b00 || o.good_bytes !== nb) begin
        bad++;
        $display("FAIL rand_xfer t=%0d got ack=%b cmd=%b bytes=%0d want ack=%b cmd=00 bytes=%0d",
                 t, o.ack_vec, o.cmd_after_ack, o.good_bytes, onehot(g), nb);
      end
      total++;
      if (o.done_vec !== onehot(g) || o.done_cnt !== 1 || o.busy_after !== 1'b0 ||
          o.err_or !== '0 || o.ack_after_drop !== '0) begin
        bad++;
        $display("FAIL rand_done t=%0d got done=%b cnt=%0d busy=%b err=%b ack=%b want done=%b cnt=1 rest 0",
                 t, o.done_vec, o.done_cnt, o.busy_after, o.err_or, o.ack_after_drop, onehot(g));
      end
      last_m = g;
    end
    bus.cl_rd = '0;
    bus.cl_wr = '0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_xfer();
    obs_t o;
    int   w = 0;
    int   g;
    bus.cl_rd = 3'b100;
    g = model_pick(bus.cl_rd, last_m);
    while (!bus.sd_rd && w < 40) begin
      @(negedge clk);
      w++;
    end
    bus.sd_ack = 1'b1;
    @(negedge clk);
    bus.sd_buff_wr = 1'b1;
    #1;
    total++;
    if (bus.cl_buff_wr !== onehot(g)) begin
      bad++;
      $display("FAIL t6_pre_reset_bwr got=%b want=%b", bus.cl_buff_wr, onehot(g));
    end
    reset     = 1'b1;
    bus.cl_rd = 3'b111;
    @(negedge clk);
    total++;
    if ({bus.sd_rd, bus.sd_wr, bus.sd_lba, bus.grant, bus.busy, bus.cl_ack, bus.cl_buff_wr,
         bus.cl_done, bus.cl_err, bus.sd_buff_din} !== '0) begin
      bad++;
      $display("FAIL t6_reset_outputs got rd=%b wr=%b lba=%h g=%0d busy=%b ack=%b bwr=%b done=%b err=%b din=%h want 0",
               bus.sd_rd, bus.sd_wr, bus.sd_lba, bus.grant, bus.busy, bus.cl_ack, bus.cl_buff_wr,
               bus.cl_done, bus.cl_err, bus.sd_buff_din);
    end
    reset          = 1'b0;
    bus.sd_ack     = 1'b0;
    bus.sd_buff_wr = 1'b0;
    last_m         = N - 1;
    g = model_pick(bus.cl_rd, last_m);
    serve(g, din_arr[g], 1, 1, 1'b1, 1'b0, o);
    total++;
    if (o.timed_out !== 1'b0 || o.grant !== 3'(g) || o.done_vec !== onehot(g)) begin
      bad++;
      $display("FAIL t6_first_after_reset got g=%0d done=%b to=%b want g=%0d done=%b",
               o.grant, o.done_vec, o.timed_out, g, onehot(g));
    end
    bus.cl_rd = '0;
  endtask

  initial begin
    bus.cl_rd      = '0;
    bus.cl_wr      = '0;
    bus.sd_ack     = 1'b0;
    bus.sd_buff_wr = 1'b0;
    for (int i = 0; i < N; i++) begin
      lba_arr[i] = '0;
      din_arr[i] = '0;
    end
    test_reset();
    test_single_read();
    test_round_robin();
    test_write_data();
    test_rd_wins();
    test_timeout();
    test_random();
    test_reset_mid_xfer();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
